sc_inst_encoder: RTL
====================

# sc_inst_encoder

Instruction encoder for the single-cycle CPU. It accepts symbolic instructions (mnemonic code plus register, immediate and target fields) on a valid/ready stream. It packs each one into a 32-bit MIPS word using the same opcode and function-field map the control unit decodes. Encoded words are buffered in a small FIFO and emitted with a word address, for loading instruction memory from a bench or a boot loader.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- ADDR_W, 32: width of the emitted word address.
- BASE_ADDR, 0: address of the first emitted word; multiple of 4.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  synchronous flush of FIFO and address counter; does not clear err.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept.
- in_mnem  in  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal; 20–31 illegal.
- in_rs, in_rt, in_rd, in_sa  in  5 each  register and shift-amount fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes word.
- out_inst  out  32  encoded word at FIFO head.
- out_addr  out  ADDR_W  address of out_inst.
- err  out  1  sticky illegal-mnemonic flag.

## Operation
- Push: the encoder accepts when in_valid & in_ready. The encoded word is written to the FIFO tail.
- R-type (codes 0–8): op=000000. Func codes: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
  - Arithmetic and logic: rs, rt, rd taken from inputs; sa forced to 0.
  - Shifts: rs forced to 0; rt, rd, sa taken from inputs.
  - jr: only rs kept; rt, rd, sa forced to 0.
- I-type, [31:26]=op, [25:21]=rs, [20:16]=rt, [15:0]=imm. Opcodes: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111. For lui, rs is forced to 0.
- J-type: j 000010, jal 000011; [25:0]=in_target.
- Unused input fields never leak into the encoded word.
- Pop: when out_valid & out_ready, the head is removed and the address counter advances by 4. The address counter wraps modulo 2^ADDR_W.
- out_addr always equals the address counter.

## Timing
- Reset values: in_ready=1, out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, FIFO empty.
- in_ready = ~full.
- out_valid = ~empty. out_inst comes from a registered FIFO slot.
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass, even when the FIFO is empty.
- Push and pop in the same cycle:
  - Legal whenever not full; occupancy is unchanged.
  - When full, in_ready=0, so only the pop occurs.
- out_inst and out_addr are held stable while out_valid & ~out_ready.
- Priority: reset > restart > push/pop.
  - restart empties the FIFO and sets out_addr=BASE_ADDR in one cycle. Any push or pop offered in that cycle is discarded.
- reset mid-stream: all state returns to reset values on the next edge. Partially drained data is lost.
- Occupancy counter is log2(DEPTH)+1 bits. The read and write pointers wrap at DEPTH.

## Configuration
- INST_ENC_CHECK_EN defined:
  - An accepted illegal mnemonic (20–31) is consumed: in_ready behaves normally.
  - The illegal word is not pushed, no address is consumed, and err sets and stays set until reset.
- INST_ENC_CHECK_EN undefined:
  - Illegal mnemonics encode as 32'h0000_0000 (sll $0,$0,0, a nop) and are pushed normally.
  - err is tied to 0.

## Test plan
- add rs=1 rt=2 rd=3, out_ready=1 → out_inst=0x00221820 at out_addr=BASE_ADDR one cycle after accept; next word is at BASE_ADDR+4.
- lw rs=6 rt=5 imm=0xFFFC, then sll rt=2 rd=4 sa=3 with in_rs=9 → 0x8CC5FFFC, then 0x000220C0 (rs suppressed).
- lui rs=5 rt=7 imm=0x1234, then jal target=0x40 → 0x3C071234, then 0x0C000040.
- out_ready=0, push 5 words with DEPTH=4 → in_ready drops after the 4th; raising out_ready drains in order with addresses +0, +4, +8, +12, then the 5th word is accepted.
- Mnemonic 25 between two adds:
  - With INST_ENC_CHECK_EN: err=1, only 2 words out, addresses contiguous.
  - Without it: 3 words out, the middle one 0x00000000.
- FIFO holding 3 words, assert restart with simultaneous push → next cycle out_valid=0, out_addr=BASE_ADDR, err unchanged; reset then clears err.

Source files
------------

// File: rtl/sc_inst_encoder_if.sv
// Stream bundle for sc_inst_encoder: symbolic instructions in, encoded words plus address out.
// The slave modport is the encoder's view. The master modport is the producer/consumer side.
interface sc_inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_sa;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_sa, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_sa, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/sc_inst_encoder.sv
// Packs symbolic instructions into 32-bit MIPS words and queues them with a word address.
// Optional macro INST_ENC_CHECK_EN: drop illegal mnemonics and raise the sticky err flag.
module sc_inst_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                restart,
  sc_inst_encoder_if.slave    bus,
  output logic                err
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  typedef enum logic [4:0] {
    M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_AND  = 5'd2,  M_OR   = 5'd3,
    M_XOR  = 5'd4,  M_SLL  = 5'd5,  M_SRL  = 5'd6,  M_SRA  = 5'd7,
    M_JR   = 5'd8,  M_ADDI = 5'd9,  M_ANDI = 5'd10, M_ORI  = 5'd11,
    M_XORI = 5'd12, M_LW   = 5'd13, M_SW   = 5'd14, M_BEQ  = 5'd15,
    M_BNE  = 5'd16, M_LUI  = 5'd17, M_J    = 5'd18, M_JAL  = 5'd19
  } mnem_e;

  localparam logic [5:0] OP_R = 6'b000000;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       enc_word;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;

  // Field packing: each form places only the fields it owns, so unused inputs never leak.
  always_comb begin
    // NOTE: default first so every path assigns enc_word and no latch is inferred.
    enc_word = '0;
    case (bus.in_mnem)
      M_ADD:  enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000};
      M_SUB:  enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010};
      M_AND:  enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100};
      M_OR:   enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101};
      M_XOR:  enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100110};
      M_SLL:  enc_word = {OP_R, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'b000000};
      M_SRL:  enc_word = {OP_R, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'b000010};
      M_SRA:  enc_word = {OP_R, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'b000011};
      M_JR:   enc_word = {OP_R, bus.in_rs, 15'd0, 6'b001000};
      M_ADDI: enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      M_ANDI: enc_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
      M_ORI:  enc_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
      M_XORI: enc_word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
      M_LW:   enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      M_SW:   enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      M_BEQ:  enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      M_BNE:  enc_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
      M_LUI:  enc_word = {6'b001111, 5'd0, bus.in_rt, bus.in_imm};
      M_J:    enc_word = {6'b000010, bus.in_target};
      M_JAL:  enc_word = {6'b000011, bus.in_target};
      default: enc_word = '0;
    endcase
  end

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign accept = bus.in_valid & ~full;
  assign pop    = ~empty & bus.out_ready;

`ifdef INST_ENC_CHECK_EN
  logic illegal;
  assign illegal = (bus.in_mnem > M_JAL);
  assign push    = accept & ~illegal;

  // Sticky until reset; restart deliberately leaves it alone.
  always_ff @(posedge clock) begin
    if (reset)                          err <= 1'b0;
    else if (!restart && accept && illegal) err <= 1'b1;
  end
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr   <= BASE_ADDR;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        addr   <= addr + ADDR_STEP;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy gates the output so stale slots are never visible.
  always_ff @(posedge clock) begin
    if (!reset && !restart && push) mem[wr_ptr] <= enc_word;
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_inst  = empty ? 32'h0 : mem[rd_ptr];
  assign bus.out_addr  = addr;

endmodule
